// File: rtl/prbs7_pkg.sv
// Shared PRBS7 (x^7 + x^6 + 1) constants, lane FSM state type and the
// per-bit mismatch function used by every checker lane.
package prbs7_pkg;

  localparam int unsigned PRBS7_ORDER = 7;
  localparam int unsigned PRBS7_TAP_A = 6;
  localparam int unsigned PRBS7_TAP_B = 7;
  localparam int unsigned PRBS7_MAX_W = 64;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } lane_state_e;

  // Bit j of the result is set when word bit j != (bit j-6) ^ (bit j-7),
  // looking back into hist (hist[0] oldest) for positions before the word.
  function automatic logic [PRBS7_MAX_W-1:0] prbs7_mismatch(
    input logic [PRBS7_ORDER-1:0] hist,
    input logic [PRBS7_MAX_W-1:0] word,
    input int unsigned            width
  );
    logic [PRBS7_MAX_W+PRBS7_ORDER-1:0] seq;
    logic [PRBS7_MAX_W-1:0]             mism;
    seq  = {word, hist};
    mism = '0;
    for (int unsigned j = 0; j < PRBS7_MAX_W; j++) begin
      if (j < width) begin
        mism[j] = seq[j + PRBS7_ORDER]
                ^ seq[j + PRBS7_ORDER - PRBS7_TAP_A]
                ^ seq[j + PRBS7_ORDER - PRBS7_TAP_B];
      end
    end
    return mism;
  endfunction

endpackage

// File: rtl/prbs7_lane.sv
// One PRBS7 checker lane: optional bit reversal, self-synchronising check,
// HUNT/LOCKED state machine and a saturating bit-error counter.
module prbs7_lane
  import prbs7_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int REVERSE    = 1,
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_CNT = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              clear_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output lane_state_e       state_o,
  output logic              err_o,
  output logic              err_nxt_o,
  output logic [CNT_W-1:0]  err_cnt_o
);

  localparam int MW    = $clog2(DATA_W + 1);
  localparam int RUN_W = $clog2(LOCK_CNT + 1);
  localparam int BAD_W = $clog2(UNLOCK_CNT + 1);
  localparam int SUM_W = ((CNT_W > MW) ? CNT_W : MW) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  lane_state_e              r_state;
  logic [RUN_W-1:0]         r_run;
  logic [BAD_W-1:0]         r_bad;
  logic                     r_hist_vld;
  logic [PRBS7_ORDER-1:0]   r_hist;
  logic                     r_err;
  logic [CNT_W-1:0]         r_cnt;

  logic [DATA_W-1:0]        w_word;
  logic [PRBS7_MAX_W-1:0]   w_mism_vec;
  logic [MW-1:0]            w_mism;
  logic [MW-1:0]            w_eff;
  logic                     w_zero;
  logic                     w_errored;
  logic                     w_fire;
  logic                     w_check;
  logic                     w_clear;
  logic [CNT_W-1:0]         w_cnt_base;
  logic [SUM_W-1:0]         w_sum;
  logic [CNT_W-1:0]         w_cnt_sat;

  always_comb begin
    w_word = '0;
    for (int i = 0; i < DATA_W; i++) begin
      w_word[i] = (REVERSE != 0) ? data_i[DATA_W-1-i] : data_i[i];
    end
  end

  assign w_mism_vec = prbs7_mismatch(r_hist, PRBS7_MAX_W'(w_word), DATA_W);

  always_comb begin
    w_mism = '0;
    for (int j = 0; j < PRBS7_MAX_W; j++) begin
      w_mism = w_mism + MW'(w_mism_vec[j]);
    end
  end

  // A dead (all-zero) lane satisfies the XOR rule, so it is charged a full word.
  assign w_zero     = (w_word == '0);
  assign w_errored  = (w_mism != '0) || w_zero;
  assign w_eff      = w_zero ? MW'(DATA_W) : w_mism;
  assign w_fire     = en_i & valid_i;
  assign w_check    = w_fire & r_hist_vld;
  assign w_clear    = en_i & clear_i;
  assign w_cnt_base = w_clear ? '0 : r_cnt;
  assign w_sum      = SUM_W'(w_cnt_base) + SUM_W'(w_eff);
  assign w_cnt_sat  = (w_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : w_sum[CNT_W-1:0];
  assign err_nxt_o  = w_check && (r_state == LOCKED) && w_errored;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= HUNT;
      r_run      <= '0;
      r_bad      <= '0;
      r_hist_vld <= 1'b0;
      r_hist     <= '0;
      r_err      <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_err <= err_nxt_o;
      if (w_clear) r_cnt <= '0;
      if (w_fire) begin
        r_hist     <= w_word[DATA_W-1 -: PRBS7_ORDER];
        r_hist_vld <= 1'b1;
      end
      if (w_check) begin
        case (r_state)
          HUNT: begin
            if (w_errored) begin
              r_run <= '0;
            end else if (r_run == RUN_W'(LOCK_CNT - 1)) begin
              r_state <= LOCKED;
              r_run   <= '0;
            end else begin
              r_run <= r_run + 1'b1;
            end
          end
          LOCKED: begin
            r_cnt <= w_cnt_sat;
            if (w_errored) begin
              // Losing lock forces the next word to re-prime the history.
              if (r_bad == BAD_W'(UNLOCK_CNT - 1)) begin
                r_state    <= HUNT;
                r_bad      <= '0;
                r_hist_vld <= 1'b0;
              end else begin
                r_bad <= r_bad + 1'b1;
              end
            end else begin
              r_bad <= '0;
            end
          end
        endcase
      end
    end
  end

  assign state_o   = r_state;
  assign err_o     = r_err;
  assign err_cnt_o = r_cnt;

endmodule

// File: rtl/prbs7_lane_checker.sv
// Multi-lane PRBS7 checker: slices the lane bus into independent lanes and
// keeps the sticky any-error flag across all of them.
module prbs7_lane_checker
  import prbs7_pkg::*;
#(
  parameter int LANES      = 4,
  parameter int DATA_W     = 8,
  parameter int REVERSE    = 1,
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_CNT = 4,
  parameter int CNT_W      = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  input  logic                    clear_i,
  input  logic                    valid_i,
  input  logic [LANES*DATA_W-1:0] data_i,
  output logic [LANES-1:0]        lock_o,
  output logic [LANES-1:0]        err_o,
  output logic [LANES*CNT_W-1:0]  err_cnt_o,
  output logic                    any_err_o
);

  lane_state_e      w_state [LANES];
  logic [LANES-1:0] w_err_nxt;
  logic             r_any_err;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    prbs7_lane #(
      .DATA_W    (DATA_W),
      .REVERSE   (REVERSE),
      .LOCK_CNT  (LOCK_CNT),
      .UNLOCK_CNT(UNLOCK_CNT),
      .CNT_W     (CNT_W)
    ) u_lane (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .en_i     (en_i),
      .clear_i  (clear_i),
      .valid_i  (valid_i),
      .data_i   (data_i[k*DATA_W +: DATA_W]),
      .state_o  (w_state[k]),
      .err_o    (err_o[k]),
      .err_nxt_o(w_err_nxt[k]),
      .err_cnt_o(err_cnt_o[k*CNT_W +: CNT_W])
    );
    assign lock_o[k] = (w_state[k] == LOCKED);
  end

  // Built from the lanes' next-cycle error so the flag rises with err_o,
  // and a clear coinciding with an error keeps that error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_any_err <= 1'b0;
    end else if (en_i && clear_i) begin
      r_any_err <= |w_err_nxt;
    end else begin
      r_any_err <= r_any_err | (|w_err_nxt);
    end
  end

  assign any_err_o = r_any_err;

endmodule

// File: tb/tb_prbs7_lane_checker.sv
// Bench for prbs7_lane_checker: dut0 uses defaults (4 lanes, reversal on),
// dut1 has 2 lanes, no reversal and a 4-bit counter (lane 1 fed MSB-first).
module tb_prbs7_lane_checker;

  logic        clk, rst, en, clr, vld;
  logic [31:0] d0;
  logic [15:0] d1;
  logic [3:0]  lock0, err0;
  logic [63:0] cnt0;
  logic        any0;
  logic [1:0]  lock1, err1;
  logic [7:0]  cnt1;
  logic        any1;

  int total = 0;
  int bad   = 0;

  // stream generators (last 7 sent bits, [0] oldest) and per-lane corruption
  logic [6:0] gen [6];
  logic [7:0] flip [6];
  bit         zero_ln [6];

  // reference model state; lanes 0-3 are dut0, 4-5 are dut1
  bit         m_primed [6];
  bit         m_locked [6];
  int         m_run [6];
  int         m_bad [6];
  int         m_cnt [6];
  bit         m_err [6];
  logic [6:0] m_hist [6];
  bit         m_any0, m_any1;

  prbs7_lane_checker #(.LANES(4), .DATA_W(8), .REVERSE(1), .LOCK_CNT(16),
                       .UNLOCK_CNT(4), .CNT_W(16)) dut0 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clear_i(clr), .valid_i(vld),
    .data_i(d0), .lock_o(lock0), .err_o(err0), .err_cnt_o(cnt0), .any_err_o(any0));

  prbs7_lane_checker #(.LANES(2), .DATA_W(8), .REVERSE(0), .LOCK_CNT(16),
                       .UNLOCK_CNT(4), .CNT_W(4)) dut1 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clear_i(clr), .valid_i(vld),
    .data_i(d1), .lock_o(lock1), .err_o(err1), .err_cnt_o(cnt1), .any_err_o(any1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] rev8(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = x[7-i];
    return r;
  endfunction

  // next 8 PRBS7 bits in time order (bit 0 earliest)
  function automatic logic [7:0] next_word(input int g);
    logic [7:0] w;
    logic       nb;
    for (int j = 0; j < 8; j++) begin
      nb     = gen[g][1] ^ gen[g][0];
      gen[g] = {nb, gen[g][6:1]};
      w[j]   = nb;
    end
    return w;
  endfunction

  function automatic logic obs_lock(input int g);
    return (g < 4) ? lock0[g] : lock1[g-4];
  endfunction

  function automatic logic obs_err(input int g);
    return (g < 4) ? err0[g] : err1[g-4];
  endfunction

  function automatic logic [15:0] obs_cnt(input int g);
    return (g < 4) ? cnt0[g*16 +: 16] : {12'b0, cnt1[(g-4)*4 +: 4]};
  endfunction

  function automatic logic [3:0] exp_lock0();
    logic [3:0] r;
    for (int g = 0; g < 4; g++) r[g] = m_locked[g];
    return r;
  endfunction

  task automatic model_reset();
    for (int g = 0; g < 6; g++) begin
      m_primed[g] = 0; m_locked[g] = 0; m_run[g] = 0; m_bad[g] = 0;
      m_cnt[g] = 0; m_err[g] = 0; m_hist[g] = '0;
    end
    m_any0 = 0;
    m_any1 = 0;
  endtask

  // one consumed word on lane g, tw in time order as the lane sees it
  task automatic model_word(input int g, input logic [7:0] tw);
    logic [14:0] seq;
    int          mism, e, cmax;
    bit          errd;
    cmax = (g < 4) ? 65535 : 15;
    if (!m_primed[g]) begin
      m_primed[g] = 1;
      m_hist[g]   = tw[7:1];
      return;
    end
    seq  = {tw, m_hist[g]};
    mism = 0;
    for (int j = 0; j < 8; j++)
      if (seq[j+7] != (seq[j+1] ^ seq[j])) mism++;
    errd = (mism != 0) || (tw == 8'h00);
    if (!m_locked[g]) begin
      m_run[g] = errd ? 0 : m_run[g] + 1;
      if (m_run[g] == 16) begin m_locked[g] = 1; m_run[g] = 0; end
    end else begin
      e = (tw == 8'h00) ? 8 : mism;
      m_cnt[g] = (m_cnt[g] + e > cmax) ? cmax : m_cnt[g] + e;
      m_err[g] = errd;
      m_bad[g] = errd ? m_bad[g] + 1 : 0;
      if (m_bad[g] == 4) begin m_locked[g] = 0; m_bad[g] = 0; m_primed[g] = 0; end
    end
    m_hist[g] = tw[7:1];
  endtask

  // drive one cycle, then advance the model for the edge that sampled it
  task automatic step(input bit v, input bit e, input bit c);
    logic [7:0] tw [6];
    for (int g = 0; g < 6; g++) begin
      if (v && e) begin
        tw[g] = next_word(g) ^ flip[g];
        if (zero_ln[g]) tw[g] = 8'h00;
      end else begin
        tw[g] = 8'($urandom);
      end
    end
    d0  = {rev8(tw[3]), rev8(tw[2]), rev8(tw[1]), rev8(tw[0])};
    d1  = {rev8(tw[5]), tw[4]};
    vld = v; en = e; clr = c;
    @(posedge clk);
    #1;
    if (e && c) begin
      for (int g = 0; g < 6; g++) m_cnt[g] = 0;
      m_any0 = 0;
      m_any1 = 0;
    end
    for (int g = 0; g < 6; g++) m_err[g] = 0;
    if (v && e)
      for (int g = 0; g < 6; g++) model_word(g, (g == 5) ? rev8(tw[5]) : tw[g]);
    for (int g = 0; g < 6; g++) begin
      if (m_err[g] && g < 4) m_any0 = 1;
      if (m_err[g] && g >= 4) m_any1 = 1;
    end
    vld = 1'b0; clr = 1'b0; en = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; vld = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
    total++; if (lock0 !== 4'h0) begin bad++; $display("FAIL rst_lock0 got=%h exp=0", lock0); end
    total++; if (err0 !== 4'h0) begin bad++; $display("FAIL rst_err0 got=%h exp=0", err0); end
    total++; if (cnt0 !== 64'h0) begin bad++; $display("FAIL rst_cnt0 got=%h exp=0", cnt0); end
    total++; if (any0 !== 1'b0) begin bad++; $display("FAIL rst_any0 got=%b exp=0", any0); end
    total++; if (lock1 !== 2'h0) begin bad++; $display("FAIL rst_lock1 got=%h exp=0", lock1); end
    total++; if (cnt1 !== 8'h0) begin bad++; $display("FAIL rst_cnt1 got=%h exp=0", cnt1); end
    total++; if (any1 !== 1'b0) begin bad++; $display("FAIL rst_any1 got=%b exp=0", any1); end
  endtask

  task automatic test_lock();
    for (int n = 1; n <= 17; n++) begin
      step(1, 1, 0);
      total++; if (lock0 !== exp_lock0()) begin bad++; $display("FAIL lock_seq n=%0d got=%h exp=%h", n, lock0, exp_lock0()); end
      if (n == 16) begin
        total++; if (lock0 !== 4'h0) begin bad++; $display("FAIL lock_early got=%h exp=0", lock0); end
      end
    end
    total++; if (lock0 !== 4'hF) begin bad++; $display("FAIL lock_17 got=%h exp=f", lock0); end
    total++; if (lock1 !== 2'b01) begin bad++; $display("FAIL lock1_17 got=%b exp=01", lock1); end
    total++; if (cnt0 !== 64'h0) begin bad++; $display("FAIL lock_cnt got=%h exp=0", cnt0); end
    total++; if (any0 !== 1'b0) begin bad++; $display("FAIL lock_any got=%b exp=0", any0); end
  endtask

  task automatic test_single_flip();
    logic [8:0] pm;
    int         p;
    p = $urandom_range(1, 7);
    flip[2] = 8'(1 << p);
    step(1, 1, 0);
    pm[0] = err0[2];
    flip[2] = 8'h00;
    for (int n = 1; n < 9; n++) begin
      step(1, 1, 0);
      pm[n] = err0[2];
    end
    total++; if (pm !== 9'b000000011) begin bad++; $display("FAIL flip_pulses p=%0d got=%b exp=000000011", p, pm); end
    total++; if (cnt0[32 +: 16] !== 16'd3) begin bad++; $display("FAIL flip_cnt2 got=%0d exp=3", cnt0[32 +: 16]); end
    total++; if ({cnt0[48 +: 16], cnt0[0 +: 32]} !== 48'h0) begin bad++; $display("FAIL flip_other got=%h exp=0", cnt0); end
    total++; if (any0 !== 1'b1) begin bad++; $display("FAIL flip_any got=%b exp=1", any0); end
    total++; if (lock0 !== 4'hF) begin bad++; $display("FAIL flip_lock got=%h exp=f", lock0); end
  endtask

  task automatic test_clear();
    step(1, 1, 1);
    total++; if (cnt0 !== 64'h0) begin bad++; $display("FAIL clr_cnt got=%h exp=0", cnt0); end
    total++; if (any0 !== 1'b0) begin bad++; $display("FAIL clr_any got=%b exp=0", any0); end
    total++; if (lock0 !== 4'hF) begin bad++; $display("FAIL clr_lock got=%h exp=f", lock0); end
  endtask

  task automatic test_dead_lane();
    zero_ln[1] = 1;
    for (int n = 1; n <= 4; n++) begin
      step(1, 1, 0);
      total++; if (lock0[1] !== (n < 4)) begin bad++; $display("FAIL dead_lock n=%0d got=%b exp=%b", n, lock0[1], n < 4); end
      total++; if (cnt0[16 +: 16] !== 16'(8 * n)) begin bad++; $display("FAIL dead_cnt n=%0d got=%0d exp=%0d", n, cnt0[16 +: 16], 8 * n); end
      total++; if (err0[1] !== 1'b1) begin bad++; $display("FAIL dead_err n=%0d got=%b exp=1", n, err0[1]); end
    end
    zero_ln[1] = 0;
    for (int n = 1; n <= 17; n++) begin
      step(1, 1, 0);
      if (n == 16) begin
        total++; if (lock0[1] !== 1'b0) begin bad++; $display("FAIL relock_early got=%b exp=0", lock0[1]); end
      end
    end
    total++; if (lock0 !== 4'hF) begin bad++; $display("FAIL relock got=%h exp=f", lock0); end
    total++; if (cnt0[16 +: 16] !== 16'd32) begin bad++; $display("FAIL dead_total got=%0d exp=32", cnt0[16 +: 16]); end
  endtask

  task automatic test_saturate();
    logic [3:0] exp_c [4];
    exp_c[0] = 4'd8; exp_c[1] = 4'd15; exp_c[2] = 4'd15; exp_c[3] = 4'd15;
    zero_ln[4] = 1;
    for (int n = 0; n < 4; n++) begin
      step(1, 1, 0);
      total++; if (cnt1[3:0] !== exp_c[n]) begin bad++; $display("FAIL sat_cnt n=%0d got=%0d exp=%0d", n, cnt1[3:0], exp_c[n]); end
    end
    total++; if (lock1[0] !== 1'b0) begin bad++; $display("FAIL sat_unlock got=%b exp=0", lock1[0]); end
    zero_ln[4] = 0;
    for (int n = 0; n < 17; n++) step(1, 1, 0);
    total++; if (lock1[0] !== 1'b1) begin bad++; $display("FAIL sat_relock got=%b exp=1", lock1[0]); end
    flip[4] = 8'h01;
    step(1, 1, 1);
    flip[4] = 8'h00;
    total++; if (cnt1[3:0] !== 4'd3) begin bad++; $display("FAIL clr_err_cnt got=%0d exp=3", cnt1[3:0]); end
    total++; if (err1[0] !== 1'b1) begin bad++; $display("FAIL clr_err_pulse got=%b exp=1", err1[0]); end
    total++; if (any1 !== 1'b1) begin bad++; $display("FAIL clr_err_any got=%b exp=1", any1); end
    total++; if (cnt0 !== 64'h0) begin bad++; $display("FAIL clr_dut0_cnt got=%h exp=0", cnt0); end
    step(1, 1, 0);
    total++; if (cnt1[3:0] !== 4'd3) begin bad++; $display("FAIL clr_err_hold got=%0d exp=3", cnt1[3:0]); end
    total++; if (lock1[1] !== 1'b0) begin bad++; $display("FAIL msb_first_lock got=%b exp=0", lock1[1]); end
  endtask

  task automatic test_reset_relock();
    int  fires, cyc;
    bit  v, e;
    rst = 1'b1; vld = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0; vld = 1'b0;
    total++; if ({lock0, err0, any0} !== 9'h0) begin bad++; $display("FAIL mid_rst0 got=%h exp=0", {lock0, err0, any0}); end
    total++; if (cnt0 !== 64'h0) begin bad++; $display("FAIL mid_rst_cnt got=%h exp=0", cnt0); end
    total++; if ({lock1, err1, cnt1, any1} !== 13'h0) begin bad++; $display("FAIL mid_rst1 got=%h exp=0", {lock1, err1, cnt1, any1}); end
    fires = 0;
    cyc   = 0;
    while (fires < 17 && cyc < 200) begin
      v = ($urandom_range(0, 2) != 0);
      e = ($urandom_range(0, 3) != 0);
      step(v, e, 0);
      cyc++;
      if (v && e) fires++;
      if (v && e && fires == 16) begin
        total++; if (lock0 !== 4'h0) begin bad++; $display("FAIL gap_lock_early got=%h exp=0", lock0); end
      end
    end
    total++; if (fires != 17) begin bad++; $display("FAIL gap_budget got=%0d exp=17", fires); end
    total++; if (lock0 !== 4'hF) begin bad++; $display("FAIL gap_relock got=%h exp=f", lock0); end
  endtask

  task automatic test_random();
    bit v, e, c;
    for (int n = 0; n < 300; n++) begin
      v = ($urandom_range(0, 4) != 0);
      e = ($urandom_range(0, 7) != 0);
      c = ($urandom_range(0, 24) == 0);
      for (int g = 0; g < 6; g++) begin
        flip[g]    = ($urandom_range(0, 9) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
        zero_ln[g] = ($urandom_range(0, 29) == 0);
      end
      step(v, e, c);
      for (int g = 0; g < 6; g++) begin
        total++; if (obs_lock(g) !== m_locked[g]) begin bad++; $display("FAIL rnd_lock n=%0d lane=%0d got=%b exp=%b", n, g, obs_lock(g), m_locked[g]); end
        total++; if (obs_err(g) !== m_err[g]) begin bad++; $display("FAIL rnd_err n=%0d lane=%0d got=%b exp=%b", n, g, obs_err(g), m_err[g]); end
        total++; if (obs_cnt(g) !== 16'(m_cnt[g])) begin bad++; $display("FAIL rnd_cnt n=%0d lane=%0d got=%0d exp=%0d", n, g, obs_cnt(g), m_cnt[g]); end
      end
      total++; if (any0 !== m_any0) begin bad++; $display("FAIL rnd_any0 n=%0d got=%b exp=%b", n, any0, m_any0); end
      total++; if (any1 !== m_any1) begin bad++; $display("FAIL rnd_any1 n=%0d got=%b exp=%b", n, any1, m_any1); end
    end
    for (int g = 0; g < 6; g++) begin flip[g] = 8'h00; zero_ln[g] = 0; end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; clr = 1'b0; vld = 1'b0; d0 = '0; d1 = '0;
    for (int g = 0; g < 6; g++) begin
      gen[g]     = 7'($urandom_range(1, 127));
      flip[g]    = 8'h00;
      zero_ln[g] = 0;
    end
    model_reset();
    test_reset();
    test_lock();
    test_single_flip();
    test_clear();
    test_dead_lane();
    test_saturate();
    test_reset_relock();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prbs7_lane_checker.md
# prbs7_lane_checker

Multi-lane, self-synchronising PRBS7 checker for the RX IOD bit-alignment and link-test path. It generalises the single-lane, fixed 8-bit fabric checker in four ways: parametrised lane count and word width, optional in-block bit reversal, a per-lane lock state machine, and per-lane saturating bit-error counters. It sits downstream of the RX IOD deserialisers in the RX_CLK_G domain and feeds status and counters to the bit-align controller or to host registers.

## Interface
- LANES, default 4: number of independent lanes.
- DATA_W, default 8: bits per lane per word. Must be ≥ 8.
- REVERSE, default 1: when 1, reverse each lane word before checking (IOD MSB-first to LSB-first).
- LOCK_CNT, default 16: consecutive clean words needed to lock.
- UNLOCK_CNT, default 4: consecutive errored words needed to drop lock.
- CNT_W, default 16: error counter width.

Ports (clock and reset first):
- clk_i  in  1  RX_CLK_G fabric clock. Single clock domain.
- rst_i  in  1  reset, synchronous, active-high.
- en_i  in  1  global enable. When low, the block holds all state and pulses nothing.
- clear_i  in  1  one-cycle pulse that zeroes all counters and the sticky flag. Lock state is unaffected.
- valid_i  in  1  data_i carries a new word on all lanes.
- data_i  in  LANES*DATA_W  lane k occupies bits [k*DATA_W +: DATA_W].
- lock_o  out  LANES  lane locked.
- err_o  out  LANES  one-cycle pulse: the lane's last word had ≥1 error while locked.
- err_cnt_o  out  LANES*CNT_W  per-lane saturating bit-error count, packed like data_i.
- any_err_o  out  1  sticky OR of every err_o since reset or clear_i.

## Operation
- Bit order: after the optional reversal, word bit 0 is earliest in time.
- Check rule, PRBS7 (x^7+x^6+1): b[n] must equal b[n-6] ^ b[n-7].
  - Evaluated over {hist[6:0], word}, where hist holds the last 7 bits of the previous valid word.
  - mism = number of failing positions, width $clog2(DATA_W+1).
- hist_vld: cleared by reset and on entry to HUNT. The first valid word after that only primes hist; no check, no counter change.
- Per-lane FSM:
  - HUNT: each clean word increments run. Any mismatch, or an all-zero word, resets run to 0. When run reaches LOCK_CNT, go to LOCKED and reset run to 0.
  - LOCKED: an errored word increments bad; a clean word resets bad to 0. When bad reaches UNLOCK_CNT, go to HUNT and clear hist_vld.
  - An all-zero word in LOCKED counts as errored, with mism = DATA_W. This catches a dead lane, which would otherwise pass the XOR check.
- Counter: only while LOCKED, err_cnt += mism, saturating at 2^CNT_W−1. Never wraps.
- Lanes are fully independent. Only en_i, clear_i and valid_i are shared.

## Timing
- Reset values: lock_o=0, err_o=0, err_cnt_o=0, any_err_o=0. FSM in HUNT, run=0, bad=0, hist_vld=0.
- Latency: err_o, err_cnt_o and lock_o change 1 cycle after the clk edge that samples the valid word.
- Sampling: valid_i=0 or en_i=0 → no state change and err_o=0. No ready/backpressure; every valid word is consumed.
- clear_i together with an errored word in the same cycle: the counter loads mism (not 0), and any_err_o loads that word's err_o.
- The word that triggers LOCKED→HUNT still counts and pulses err_o.
- rst_i mid-stream: all state returns to reset values on the next edge. The following word primes hist only.

## Structure
- Package prbs7_pkg holds:
  - PRBS7 tap constants (6, 7) and the order constant 7.
  - Lane FSM state enum {HUNT, LOCKED}.
  - Function prbs7_mismatch(hist, word) returning the mismatch vector.
- Sub-module prbs7_lane, one per lane: reversal, check, FSM and counter. Instantiated LANES times by generate.
- The top level handles only slicing/packing and any_err_o.

## Test plan
- Clean PRBS7 stream, LANES=4, DATA_W=8, LOCK_CNT=16 → lock_o=4'hF exactly 1 cycle after the 17th valid word; err_cnt_o all 0; any_err_o=0.
- While locked, flip one bit on lane 2 → err_o[2] pulses on 2 consecutive words (positions n, n+6, n+7 may straddle words), lane 2 count = 3, other lanes 0, any_err_o=1.
- Drive lane 1 all-zero for 4 words while locked → count += 32, lock_o[1] falls after the 4th word. Restoring clean data → relock after 1 priming word + 16 clean words.
- CNT_W=4, continuous errors → counter stops at 15 and never wraps. clear_i on the same cycle as a 3-error word → count=3.
- REVERSE=0 with MSB-first input → never locks. REVERSE=1 with the same input → locks after 17 words.
- Assert rst_i for 1 cycle mid-lock → all outputs 0 next cycle. Relock takes exactly 17 words; valid_i gaps and en_i=0 stretch the wall-clock time but not the word count.
